// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared bus widths, FSM state encoding and helpers for the memory arbiter.
package mem_arbiter_pkg;
  localparam int REG_BUS = 32;
  localparam int INST_ADDR_BUS = 32;
  localparam int SEL_BUS = 4;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INST_BUSY = 2'd1,
    ST_DATA_BUSY = 2'd2,
    ST_RESP      = 2'd3
  } state_e;
  function automatic logic is_busy(input state_e s);
    return s == ST_INST_BUSY || s == ST_DATA_BUSY;
  endfunction
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: counts bus-wait cycles and flags the cycle in which LIMIT is reached.
module mem_arb_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst || clear_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + CW'(1);
  end
  assign expired_o = en_i && cnt_q == CW'(LIMIT - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-bus arbiter for fetch and data ports, data has priority.
// Optional bus-wait timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_req_i,
  input  logic [INST_ADDR_BUS-1:0] inst_addr_i,
  output logic [REG_BUS-1:0]       inst_rdata_o,
  output logic                     inst_ack_o,
  output logic                     stallreq_inst_o,
  input  logic                     data_req_i,
  input  logic                     data_we_i,
  input  logic [SEL_BUS-1:0]       data_sel_i,
  input  logic [INST_ADDR_BUS-1:0] data_addr_i,
  input  logic [REG_BUS-1:0]       data_wdata_i,
  output logic [REG_BUS-1:0]       data_rdata_o,
  output logic                     data_ack_o,
  output logic                     stallreq_data_o,
  input  logic                     flush_i,
  output logic                     bus_req_o,
  output logic                     bus_we_o,
  output logic [SEL_BUS-1:0]       bus_sel_o,
  output logic [INST_ADDR_BUS-1:0] bus_addr_o,
  output logic [REG_BUS-1:0]       bus_wdata_o,
  input  logic [REG_BUS-1:0]       bus_rdata_i,
  input  logic                     bus_ack_i,
  output logic                     bus_err_o
);
  state_e state_q, state_d;
  logic data_q, flushed_q, bus_we_q, timeout, busy, resp, grant;
  logic [SEL_BUS-1:0] bus_sel_q;
  logic [INST_ADDR_BUS-1:0] bus_addr_q;
  logic [REG_BUS-1:0] bus_wdata_q, resp_q, inst_hold_q, data_hold_q;

  assign busy  = is_busy(state_q);
  assign resp  = state_q == ST_RESP;
  assign grant = state_q == ST_IDLE && (data_req_i || inst_req_i);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = data_req_i ? ST_DATA_BUSY : inst_req_i ? ST_INST_BUSY : ST_IDLE;
      ST_INST_BUSY, ST_DATA_BUSY: state_d = (bus_ack_i || timeout) ? ST_RESP : state_q;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data is shown live during the ack cycle and held afterwards, so a flush in RESP leaves it untouched.
  always_comb begin
    bus_req_o       = busy;
    inst_ack_o      = resp && !data_q && !flushed_q && !flush_i;
    data_ack_o      = resp && data_q;
    inst_rdata_o    = inst_ack_o ? resp_q : inst_hold_q;
    data_rdata_o    = data_ack_o ? resp_q : data_hold_q;
    stallreq_inst_o = inst_req_i && !inst_ack_o;
    stallreq_data_o = data_req_i && !data_ack_o;
  end

  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= 1'b0;
      flushed_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      resp_q      <= '0;
      inst_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      if (grant) begin
        data_q      <= data_req_i;
        flushed_q   <= 1'b0;
        bus_we_q    <= data_req_i && data_we_i;
        bus_sel_q   <= data_req_i ? data_sel_i : '1;
        bus_addr_q  <= data_req_i ? data_addr_i : inst_addr_i;
        bus_wdata_q <= data_req_i ? data_wdata_i : '0;
      end
      if (state_q == ST_INST_BUSY && flush_i) flushed_q <= 1'b1;
      if (busy && bus_ack_i) resp_q <= bus_we_q ? '0 : bus_rdata_i;
      else if (busy && timeout) resp_q <= '0;
      if (inst_ack_o) inst_hold_q <= resp_q;
      if (data_ack_o) data_hold_q <= resp_q;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic err_q;
  mem_arb_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (!busy),
    .en_i      (busy),
    .expired_o (timeout)
  );
  always_ff @(posedge clk) begin
    if (rst || grant) err_q <= 1'b0;
    else if (busy && !bus_ack_i && timeout) err_q <= 1'b1;
  end
  assign bus_err_o = resp && err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES != 0;
  assign timeout   = 1'b0;
  assign bus_err_o = 1'b0;
`endif
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning bus-wait limit in cycles, only used with MEM_ARB_TIMEOUT_EN.
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-high reset.
REQ-003 SHALL have ports: inst_req_i in 1 fetch request; inst_addr_i in 32 fetch address; inst_rdata_o out 32 fetched word; inst_ack_o out 1 fetch done pulse; stallreq_inst_o out 1 fetch stall to ctrl.
REQ-004 SHALL have ports: data_req_i in 1; data_we_i in 1; data_sel_i in 4 byte enables; data_addr_i in 32; data_wdata_i in 32; data_rdata_o out 32; data_ack_o out 1; stallreq_data_o out 1.
REQ-005 SHALL have ports: flush_i in 1 pipeline flush from ctrl.
REQ-006 SHALL have ports: bus_req_o out 1; bus_we_o out 1; bus_sel_o out 4; bus_addr_o out 32; bus_wdata_o out 32; bus_rdata_i in 32; bus_ack_i in 1; bus_err_o out 1 timeout flag.

Function
REQ-007 SHALL implement FSM states IDLE, INST_BUSY, DATA_BUSY, RESP; requests sampled only in IDLE.
REQ-008 IDLE: data_req_i high -> latch data request, go DATA_BUSY; else inst_req_i high -> latch inst_addr_i, go INST_BUSY; else stay IDLE.
REQ-009 Simultaneous requests in IDLE: data wins; fetch stays stalled, granted in first IDLE after data RESP.
REQ-010 bus_req_o SHALL be high exactly while in INST_BUSY or DATA_BUSY; bus_addr_o/we/sel/wdata stable from latched values throughout.
REQ-011 Fetch access: bus_we_o=0, bus_sel_o=4'b1111, bus_wdata_o=0.
REQ-012 BUSY with bus_ack_i high -> latch bus_rdata_i, go RESP; minimum grant-to-ack_o latency 2 cycles (grant N, bus_req_o N+1, RESP N+2 if bus_ack_i at N+1).
REQ-013 RESP: matching ack_o high exactly one cycle, rdata_o valid that cycle (data write returns 0); RESP -> IDLE unconditionally.
REQ-014 rdata_o SHALL hold last value until next RESP for same port.
REQ-015 stallreq_inst_o = inst_req_i & ~inst_ack_o; stallreq_data_o = data_req_i & ~data_ack_o (combinational).
REQ-016 flush_i in INST_BUSY or INST RESP: bus access completes normally, inst_ack_o suppressed, inst_rdata_o unchanged; flush_i never affects data accesses.
REQ-017 bus_ack_i outside BUSY states SHALL be ignored.

Reset
REQ-018 rst SHALL force IDLE next edge, all outputs 0 (bus_req_o, acks, bus_err_o, rdata_o, bus_addr_o etc.), including mid-access; in-flight request dropped, no ack issued.

Configuration
REQ-019 Macro MEM_ARB_TIMEOUT_EN defined: BUSY cycle counter; on TIMEOUT_CYCLES cycles without bus_ack_i, drop bus_req_o, go RESP, pulse ack_o with rdata_o=0 and bus_err_o=1 for that RESP cycle; counter clears on every BUSY entry.
REQ-020 Macro undefined: BUSY waits indefinitely; bus_err_o tied 0; no counter logic.

Structure
REQ-021 State encodings and bus widths (RegBus, InstAddrBus) SHALL live in shared defines.v; no local width literals.
REQ-022 Timeout counter SHALL be sub-module mem_arb_timer (clear, enable, expired), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-023 Fetch 0x00000010, bus_ack_i one cycle after bus_req_o with rdata 0x24020005 -> inst_ack_o pulse 2 cycles after grant, inst_rdata_o=0x24020005, stallreq_inst_o low same cycle.
REQ-024 inst_req_i and data_req_i (write 0xDEADBEEF to 0x80, sel 4'b1111) same IDLE cycle -> data bus cycle first with we=1, data_ack_o, then fetch; stallreq_inst_o high throughout data access.
REQ-025 Fetch with bus_ack_i delayed 5 cycles, flush_i pulsed cycle 2 -> bus_req_o held 5 cycles, no inst_ack_o, FSM returns IDLE.
REQ-026 rst asserted during DATA_BUSY -> next cycle bus_req_o=0, state IDLE, no data_ack_o even if bus_ack_i arrives.
REQ-027 With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no bus_ack_i -> bus_req_o drops after 4 cycles, data_ack_o and bus_err_o high one cycle, data_rdata_o=0; without macro bus_req_o stays high.
